// File: rtl/cs_hpm_bank_pkg.sv
// Shared constants for the machine counter / HPM CSR bank: CSR addresses,
// the event selector type and the writable-bit mask of mcountinhibit.
package cs_hpm_bank_pkg;

    localparam logic [11:0] CSR_MCYCLE             = 12'hB00;
    localparam logic [11:0] CSR_MCYCLEH            = 12'hB80;
    localparam logic [11:0] CSR_MINSTRET           = 12'hB02;
    localparam logic [11:0] CSR_MINSTRETH          = 12'hB82;
    localparam logic [11:0] CSR_MHPMCOUNTER3_BASE  = 12'hB03;
    localparam logic [11:0] CSR_MHPMCOUNTER3H_BASE = 12'hB83;
    localparam logic [11:0] CSR_MHPMEVENT3_BASE    = 12'h323;
    localparam logic [11:0] CSR_MCOUNTINHIBIT      = 12'h320;
    localparam logic [11:0] CSR_CYCLE              = 12'hC00;
    localparam logic [11:0] CSR_CYCLEH             = 12'hC80;

    // Counter slot indices inside a 32-entry counter window.
    localparam int unsigned IDX_CYCLE   = 0;
    localparam int unsigned IDX_INSTRET = 2;
    localparam int unsigned IDX_HPM0    = 3;

    typedef logic [4:0] hpm_sel_t;

    // mcountinhibit: CY, IR and one bit per implemented HPM counter are writable.
    function automatic logic [31:0] inhibit_mask(input int unsigned num_hpm);
        logic [31:0] m;
        m = 32'h0000_0005;
        for (int unsigned i = 0; i < 29; i++) begin
            if (i < num_hpm) m[IDX_HPM0 + i] = 1'b1;
        end
        return m;
    endfunction

endpackage

// File: rtl/cs_hpm_counter.sv
// One CNT_WIDTH event counter with independent 32-bit lo/hi CSR write ports.
// A write to either half wins over the increment for that cycle; no carry crosses halves on write.
module cs_hpm_counter #(
    parameter int unsigned CNT_WIDTH = 64
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 wr_lo_i,
    input  logic                 wr_hi_i,
    input  logic [31:0]          wdata_i,
    input  logic                 inc_i,
    input  logic                 inhibit_i,
    output logic [CNT_WIDTH-1:0] value_o,
    output logic                 wrap_o
);

    logic [CNT_WIDTH-1:0] cnt;
    logic                 step;

    assign step    = inc_i && !inhibit_i && !wr_lo_i && !wr_hi_i;
    assign wrap_o  = step && (&cnt);
    assign value_o = cnt;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt <= '0;
        end else begin
            if (wr_lo_i) cnt[31:0] <= wdata_i;
            if (wr_hi_i) cnt[CNT_WIDTH-1:32] <= wdata_i[CNT_WIDTH-33:0];
            if (step)    cnt <= cnt + CNT_WIDTH'(1);
        end
    end

endmodule

// File: rtl/cs_hpm_bank.sv
// Machine counter / performance-monitor CSR bank: mcycle, minstret, NUM_HPM HPM pairs,
// mcountinhibit and user shadows. Overflow interrupt built only with CERES_HPM_OVF_IRQ_EN.
module cs_hpm_bank
    import cs_hpm_bank_pkg::*;
#(
    parameter int unsigned XLEN       = 32,
    parameter int unsigned NUM_HPM    = 4,
    parameter int unsigned CNT_WIDTH  = 64,
    parameter int unsigned NUM_EVENTS = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  count_en_i,
    input  logic                  retire_i,
    input  logic [NUM_EVENTS-1:0] event_i,
    input  logic                  rd_en_i,
    input  logic                  wr_en_i,
    input  logic [11:0]           csr_idx_i,
    input  logic [XLEN-1:0]       csr_wdata_i,
    output logic [XLEN-1:0]       csr_rdata_o,
    output logic                  csr_hit_o,
    output logic                  ovf_irq_o
);

    localparam int unsigned NUM_CNT  = IDX_HPM0 + NUM_HPM;
    localparam int unsigned NH       = (NUM_HPM == 0) ? 1 : NUM_HPM;
    localparam logic [31:0] INH_MASK = inhibit_mask(NUM_HPM);

    logic [NUM_EVENTS-1:0] event_q;
    logic                  retire_q;
    logic [31:0]           inhibit;
    hpm_sel_t              sel [NH];
    logic [NH-1:0]         of_flag;

    logic [CNT_WIDTH-1:0]  cnt_val [NUM_CNT];
    logic [NUM_CNT-1:0]    inc;
    logic [NUM_CNT-1:0]    wr_lo;
    logic [NUM_CNT-1:0]    wr_hi;
    logic [NUM_CNT-1:0]    wrap;

    logic [4:0]            sub;
    logic                  hi_half;
    logic                  cnt_range;
    logic                  shadow_range;
    logic                  evt_range;
    logic                  evt_wr;
    logic [63:0]           ext;
    logic [31:0]           rd_val;

    // Address decode: each window is 32 entries; bit 7 selects the upper half.
    assign sub          = csr_idx_i[4:0];
    assign hi_half      = csr_idx_i[7];
    assign cnt_range    = (csr_idx_i & 12'hF60) == (CSR_MCYCLE & 12'hF60);
    assign shadow_range = (csr_idx_i & 12'hF60) == (CSR_CYCLE & 12'hF60);
    assign evt_range    = (csr_idx_i & 12'hFE0) == CSR_MCOUNTINHIBIT;
    assign evt_wr       = wr_en_i && evt_range;
    assign csr_hit_o    = cnt_range || shadow_range || evt_range;

    always_comb begin
        wr_lo = '0;
        wr_hi = '0;
        for (int unsigned i = 0; i < NUM_CNT; i++) begin
            if (wr_en_i && cnt_range && (32'(sub) == i)) begin
                if (hi_half) wr_hi[i] = 1'b1;
                else         wr_lo[i] = 1'b1;
            end
        end
    end

    always_comb begin
        inc = '0;
        inc[IDX_CYCLE]   = count_en_i;
        inc[IDX_INSTRET] = retire_q;
        for (int unsigned k = 0; k < NUM_HPM; k++) begin
            for (int unsigned e = 0; e < NUM_EVENTS; e++) begin
                if (sel[k] == hpm_sel_t'(e + 1)) inc[IDX_HPM0 + k] = event_q[e];
            end
        end
    end

    for (genvar i = 0; i < NUM_CNT; i++) begin : g_cnt
        if (i == 1) begin : g_time
            // Slot 1 is the time CSR, which lives elsewhere; it reads 0 here.
            assign cnt_val[i] = '0;
            assign wrap[i]    = 1'b0;
        end else begin : g_ctr
            cs_hpm_counter #(
                .CNT_WIDTH (CNT_WIDTH)
            ) u_ctr (
                .clk_i     (clk_i),
                .rst_i     (rst_i),
                .wr_lo_i   (wr_lo[i]),
                .wr_hi_i   (wr_hi[i]),
                .wdata_i   (csr_wdata_i),
                .inc_i     (inc[i]),
                .inhibit_i (inhibit[i]),
                .value_o   (cnt_val[i]),
                .wrap_o    (wrap[i])
            );
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            event_q  <= '0;
            retire_q <= 1'b0;
            inhibit  <= '0;
            for (int unsigned k = 0; k < NH; k++) sel[k] <= '0;
        end else begin
            event_q  <= event_i;
            retire_q <= retire_i;
            if (evt_wr && (sub == 5'd0)) inhibit <= csr_wdata_i & INH_MASK;
            for (int unsigned k = 0; k < NUM_HPM; k++) begin
                if (evt_wr && (32'(sub) == IDX_HPM0 + k)) begin
                    sel[k] <= (32'(csr_wdata_i[4:0]) > NUM_EVENTS) ? '0 : csr_wdata_i[4:0];
                end
            end
        end
    end

`ifdef CERES_HPM_OVF_IRQ_EN
    logic ovf_q;

    // Sticky OF: an increment wrap in the same cycle as a software clear keeps the flag set.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            of_flag <= '0;
            ovf_q   <= 1'b0;
        end else begin
            for (int unsigned k = 0; k < NUM_HPM; k++) begin
                if (wrap[IDX_HPM0 + k])
                    of_flag[k] <= 1'b1;
                else if (evt_wr && (32'(sub) == IDX_HPM0 + k))
                    of_flag[k] <= csr_wdata_i[31];
            end
            ovf_q <= |of_flag;
        end
    end

    assign ovf_irq_o = ovf_q;
`else
    assign of_flag   = '0;
    assign ovf_irq_o = 1'b0;
`endif

    always_comb begin
        ext    = '0;
        rd_val = '0;
        if (cnt_range || shadow_range) begin
            for (int unsigned i = 0; i < NUM_CNT; i++) begin
                if (32'(sub) == i) ext = 64'(cnt_val[i]);
            end
            rd_val = hi_half ? ext[63:32] : ext[31:0];
        end else if (evt_range) begin
            if (sub == 5'd0) rd_val = inhibit;
            for (int unsigned k = 0; k < NUM_HPM; k++) begin
                if (32'(sub) == IDX_HPM0 + k) rd_val = {of_flag[k], 26'b0, sel[k]};
            end
        end
    end

    assign csr_rdata_o = (rd_en_i && csr_hit_o) ? rd_val : '0;

    logic unused_bits;
    assign unused_bits = ^{inhibit, wr_lo[1], wr_hi[1], inc[1], wrap, of_flag};

endmodule

// File: tb/tb_cs_hpm_bank.sv
// Directed bench for cs_hpm_bank: table of single-cycle vectors plus hand sequences
// for overflow and mid-run reset.
module tb_cs_hpm_bank;

`ifdef CERES_HPM_OVF_IRQ_EN
    localparam bit OVF_EN = 1'b1;
`else
    localparam bit OVF_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        count_en = 1'b0;
    logic        retire = 1'b0;
    logic [7:0]  events = '0;
    logic        rd_en = 1'b0;
    logic        wr_en = 1'b0;
    logic [11:0] csr_idx = '0;
    logic [31:0] csr_wdata = '0;
    logic [31:0] csr_rdata;
    logic        csr_hit;
    logic        ovf_irq;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    cs_hpm_bank #(
        .XLEN       (32),
        .NUM_HPM    (4),
        .CNT_WIDTH  (64),
        .NUM_EVENTS (8)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .count_en_i  (count_en),
        .retire_i    (retire),
        .event_i     (events),
        .rd_en_i     (rd_en),
        .wr_en_i     (wr_en),
        .csr_idx_i   (csr_idx),
        .csr_wdata_i (csr_wdata),
        .csr_rdata_o (csr_rdata),
        .csr_hit_o   (csr_hit),
        .ovf_irq_o   (ovf_irq)
    );

    typedef struct {
        logic        rd;
        logic        wr;
        logic [11:0] idx;
        logic [31:0] wdata;
        logic        cen;
        logic        ret;
        logic [7:0]  ev;
        logic        chk;
        logic [31:0] exp_rd;
        logic        exp_hit;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic rd, input logic wr, input logic [11:0] idx,
                       input logic [31:0] wdata, input logic cen, input logic ret,
                       input logic [7:0] ev, input logic chk, input logic [31:0] exp_rd,
                       input logic exp_hit);
        vec_t v;
        v.rd = rd; v.wr = wr; v.idx = idx; v.wdata = wdata; v.cen = cen; v.ret = ret;
        v.ev = ev; v.chk = chk; v.exp_rd = exp_rd; v.exp_hit = exp_hit;
        tbl.push_back(v);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", name, act, exp);
        end
    endtask

    // One clock cycle: inputs change just after the edge, outputs are sampled at the falling edge.
    task automatic cyc(input logic rd, input logic wr, input logic [11:0] idx,
                       input logic [31:0] wdata, input logic cen, input logic ret,
                       input logic [7:0] ev);
        @(posedge clk);
        #1;
        rd_en = rd; wr_en = wr; csr_idx = idx; csr_wdata = wdata;
        count_en = cen; retire = ret; events = ev;
        @(negedge clk);
    endtask

    initial begin
        // reset state
        add(1, 0, 12'hB00, 0, 0, 0, 0, 1, 32'h0, 1);
        add(1, 0, 12'h320, 0, 0, 0, 0, 1, 32'h0, 1);
        add(1, 0, 12'h323, 0, 0, 0, 0, 1, 32'h0, 1);
        // mcycle counts in the same cycle as count_en
        for (int i = 0; i < 10; i++) add(0, 0, 12'h000, 0, 1, 0, 0, 0, 0, 0);
        add(1, 0, 12'hB00, 0, 0, 0, 0, 1, 32'd10, 1);
        add(1, 0, 12'hB80, 0, 0, 0, 0, 1, 32'd0, 1);
        // event select 2 -> event_i[1], one-cycle latency
        add(0, 1, 12'h323, 32'd2, 0, 0, 0, 0, 0, 0);
        add(1, 0, 12'h323, 0, 0, 0, 0, 1, 32'd2, 1);
        add(1, 0, 12'hB03, 0, 0, 0, 8'h02, 1, 32'd0, 1);
        add(1, 0, 12'hB03, 0, 0, 0, 8'h02, 1, 32'd0, 1);
        add(1, 0, 12'hB03, 0, 0, 0, 8'h02, 1, 32'd1, 1);
        add(1, 0, 12'hB03, 0, 0, 0, 8'h02, 1, 32'd2, 1);
        add(1, 0, 12'hB03, 0, 0, 0, 8'h02, 1, 32'd3, 1);
        add(1, 0, 12'hB03, 0, 0, 0, 8'h00, 1, 32'd4, 1);
        add(1, 0, 12'hB03, 0, 0, 0, 8'h00, 1, 32'd5, 1);
        add(1, 0, 12'hB03, 0, 0, 0, 8'h00, 1, 32'd5, 1);
        // selector WARL: 9 is out of range, 8 is the top legal value
        add(0, 1, 12'h323, 32'd9, 0, 0, 0, 0, 0, 0);
        add(1, 0, 12'h323, 0, 0, 0, 0, 1, 32'd0, 1);
        add(0, 1, 12'h323, 32'd8, 0, 0, 0, 0, 0, 0);
        add(1, 0, 12'h323, 0, 0, 0, 0, 1, 32'd8, 1);
        // write beats increment, then carry into the high half by counting
        add(1, 1, 12'hB00, 32'hFFFF_FFFF, 1, 0, 0, 1, 32'd10, 1);
        add(1, 0, 12'hB00, 0, 1, 0, 0, 1, 32'hFFFF_FFFF, 1);
        add(1, 0, 12'hB00, 0, 0, 0, 0, 1, 32'h0, 1);
        add(1, 0, 12'hB80, 0, 0, 0, 0, 1, 32'h1, 1);
        // high-half write leaves the low half alone
        add(0, 1, 12'hB83, 32'h0000_ABCD, 0, 0, 0, 0, 0, 0);
        add(1, 0, 12'hB83, 0, 0, 0, 0, 1, 32'h0000_ABCD, 1);
        add(1, 0, 12'hB03, 0, 0, 0, 0, 1, 32'd5, 1);
        // minstret inhibit
        add(0, 1, 12'h320, 32'h4, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) add(1, 0, 12'hB02, 0, 0, 1, 0, 1, 32'd0, 1);
        add(1, 0, 12'hB02, 0, 0, 0, 0, 1, 32'd0, 1);
        add(0, 1, 12'h320, 32'h0, 0, 1, 0, 0, 0, 0);
        add(1, 0, 12'hB02, 0, 0, 1, 0, 1, 32'd0, 1);
        add(1, 0, 12'hB02, 0, 0, 0, 0, 1, 32'd1, 1);
        add(1, 0, 12'hB02, 0, 0, 0, 0, 1, 32'd2, 1);
        add(1, 0, 12'hB02, 0, 0, 0, 0, 1, 32'd2, 1);
        add(0, 1, 12'h320, 32'hFFFF_FFFF, 0, 0, 0, 0, 0, 0);
        add(1, 0, 12'h320, 0, 0, 0, 0, 1, 32'h0000_007D, 1);
        add(0, 1, 12'h320, 32'h0, 0, 0, 0, 0, 0, 0);
        // shadows: writes ignored, reads live
        add(1, 1, 12'hC00, 32'h1234, 0, 0, 0, 1, 32'h0, 1);
        add(1, 0, 12'hB00, 0, 0, 0, 0, 1, 32'h0, 1);
        add(1, 1, 12'hC80, 32'h55, 0, 0, 0, 1, 32'h1, 1);
        add(1, 0, 12'hC80, 0, 0, 0, 0, 1, 32'h1, 1);
        add(1, 0, 12'hC02, 0, 0, 0, 0, 1, 32'd2, 1);
        // misses, unimplemented indices, rd_en low
        add(1, 0, 12'h3FF, 0, 0, 0, 0, 1, 32'h0, 0);
        add(1, 1, 12'hB07, 32'h1234, 0, 0, 0, 1, 32'h0, 1);
        add(1, 0, 12'hB07, 0, 0, 0, 0, 1, 32'h0, 1);
        add(0, 0, 12'hB80, 0, 0, 0, 0, 1, 32'h0, 1);
        add(1, 0, 12'h322, 0, 0, 0, 0, 1, 32'h0, 1);

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("reset irq", {31'b0, ovf_irq}, 32'h0);

        foreach (tbl[i]) begin
            cyc(tbl[i].rd, tbl[i].wr, tbl[i].idx, tbl[i].wdata, tbl[i].cen, tbl[i].ret, tbl[i].ev);
            if (tbl[i].chk) begin
                check($sformatf("row%0d rdata %h", i, tbl[i].idx), csr_rdata, tbl[i].exp_rd);
                check($sformatf("row%0d hit %h", i, tbl[i].idx), {31'b0, csr_hit}, {31'b0, tbl[i].exp_hit});
            end
        end

        // overflow of HPM4 via increment
        cyc(0, 1, 12'hB04, 32'hFFFF_FFFF, 0, 0, 0);
        cyc(0, 1, 12'hB84, 32'hFFFF_FFFF, 0, 0, 0);
        cyc(0, 1, 12'h324, 32'h1, 0, 0, 0);
        cyc(1, 0, 12'hB84, 0, 0, 0, 8'h01);
        check("ovf pre hi", csr_rdata, 32'hFFFF_FFFF);
        cyc(1, 0, 12'hB04, 0, 0, 0, 0);
        check("ovf pre lo", csr_rdata, 32'hFFFF_FFFF);
        cyc(1, 0, 12'hB04, 0, 0, 0, 0);
        check("ovf wrap lo", csr_rdata, 32'h0);
        check("ovf irq latency", {31'b0, ovf_irq}, 32'h0);
        cyc(1, 0, 12'hB84, 0, 0, 0, 0);
        check("ovf wrap hi", csr_rdata, 32'h0);
        check("ovf irq set", {31'b0, ovf_irq}, {31'b0, OVF_EN});
        cyc(1, 0, 12'h324, 0, 0, 0, 0);
        check("ovf of flag", csr_rdata, OVF_EN ? 32'h8000_0001 : 32'h0000_0001);
        cyc(1, 0, 12'hB03, 0, 0, 0, 0);
        check("hpm3 untouched", csr_rdata, 32'd5);
        cyc(0, 1, 12'h324, 32'h1, 0, 0, 0);
        cyc(1, 0, 12'h324, 0, 0, 0, 0);
        check("of cleared", csr_rdata, 32'h1);
        check("irq lag", {31'b0, ovf_irq}, {31'b0, OVF_EN});
        cyc(0, 0, 12'h000, 0, 0, 0, 0);
        check("irq dropped", {31'b0, ovf_irq}, 32'h0);

        // reset while an event is in flight
        cyc(0, 0, 12'h000, 0, 0, 0, 8'h01);
        @(posedge clk);
        #1 rst = 1'b1; events = '0;
        @(posedge clk);
        #1 rst = 1'b0;
        cyc(1, 0, 12'hB04, 0, 0, 0, 0);
        check("rst hpm4", csr_rdata, 32'h0);
        cyc(1, 0, 12'hB04, 0, 0, 0, 0);
        check("rst no stale event", csr_rdata, 32'h0);
        cyc(1, 0, 12'h324, 0, 0, 0, 0);
        check("rst event4", csr_rdata, 32'h0);
        cyc(1, 0, 12'hB80, 0, 0, 0, 0);
        check("rst mcycleh", csr_rdata, 32'h0);
        check("rst irq", {31'b0, ovf_irq}, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cs_hpm_bank.md
Name: cs_hpm_bank

Overview:
Parametrised machine counter/performance-monitor CSR bank for the execute stage. It replaces the fixed mcycle/minstret pair with the following:
- mcycle and minstret.
- NUM_HPM programmable mhpmcounterN/mhpmeventN pairs.
- mcountinhibit.
- User read-only shadows.
- Optional overflow interrupt.

The main CSR file forwards counter-range accesses here and muxes csr_rdata_o in when csr_hit_o is asserted.

Parameters:
XLEN, 32, CSR data width (fixed 32; RV32 split-half addressing)
NUM_HPM, 4, number of programmable counters, 0..29, mapped to indices 3..3+NUM_HPM-1
CNT_WIDTH, 64, implemented counter width, 33..64; bits above CNT_WIDTH read 0 and ignore writes
NUM_EVENTS, 8, width of the event input vector, 1..31

Ports:
clk_i  input  1  core clock
rst_i  input  1  synchronous active-high reset
count_en_i  input  1  core not stalled this cycle; gates mcycle
retire_i  input  1  one instruction retired this cycle
event_i  input  NUM_EVENTS  per-cycle event pulses
rd_en_i  input  1  CSR read strobe
wr_en_i  input  1  CSR write strobe, already qualified by the pipeline
csr_idx_i  input  12  CSR address
csr_wdata_i  input  XLEN  final write data (RMW already resolved)
csr_rdata_o  output  XLEN  read data; 0 when no hit or rd_en_i is low
csr_hit_o  output  1  csr_idx_i decodes to a register in this bank
ovf_irq_o  output  1  overflow interrupt pending (feature-dependent)

Behaviour:
- Reset (rst_i sampled high at posedge): every counter, mhpmevent and mcountinhibit is 0. ovf_irq_o=0. Reset mid-operation discards any pending registered events.
- Event pipeline:
  - event_i and retire_i are registered once. A counter increments one cycle after the pulse is presented (latency 1).
  - mcycle is unregistered: it increments in the same cycle count_en_i is high.
- Address map:
  - MCYCLE B00/B80, MINSTRET B02/B82.
  - MHPMCOUNTERk at B00+k / B80+k.
  - MHPMEVENTk at 320+k, MCOUNTINHIBIT at 320.
  - Read-only shadows at C00..C1F / C80..C9F.
  - Indices k >= 3+NUM_HPM hit, read 0, and ignore writes.
- Increment rule, per counter:
  - Counts +1 when its source is active and its mcountinhibit bit is 0.
  - Sources: mcycle = count_en_i; minstret = registered retire; hpm k = registered event_i[sel-1] when sel != 0.
  - Wraps modulo 2^CNT_WIDTH.
- Write/increment collision:
  - A CSR write to either half of a counter in the same cycle wins.
  - That counter's increment is suppressed for that cycle.
  - The other half keeps its old value; there is no carry into or out of the written half.
- mhpmevent: bits [4:0] hold sel (WARL). Writing sel > NUM_EVENTS stores 0. Other bits read 0, except bit 31 when the optional feature is enabled.
- mcountinhibit (WARL): bits 0, 2 and 3..3+NUM_HPM-1 are writable; bit 1 reads 0.
- Shadow addresses:
  - Writes to C-range addresses are ignored; csr_hit_o is still 1 (the CSR file raises the illegal-instruction trap).
  - Reads return the live value.
- Reads are combinational and return the pre-write register value in a cycle that also writes.

Optional Feature:
Macro: CERES_HPM_OVF_IRQ_EN.
- When defined:
  - mhpmevent bit 31 is the sticky OF flag.
  - OF is set when counter k wraps from all-ones to 0 via increment, not via a CSR write.
  - A software write of OF=0 clears it. If the wrap and the clear happen in the same cycle, the set wins.
  - ovf_irq_o is registered and equals the OR of all OF bits, one cycle after the bit is set.
- When not defined: bit 31 reads 0 and ignores writes; ovf_irq_o is tied 0.

Decomposition:
- ceres_param: CSR address localparams (MCYCLE, MINSTRET, MHPMCOUNTER3_BASE, MHPMEVENT3_BASE, MCOUNTINHIBIT, CYCLE/CYCLEH shadow bases) and a hpm_sel_t typedef (5 bits).
- One sub-module, cs_hpm_counter: a single CNT_WIDTH counter with lo/hi write ports, inc_i, inhibit_i, and wrap_o. It is instantiated via generate for mcycle, minstret and each hpm.

Test Plan:
- Reset, then mcountinhibit=0, count_en_i high for 10 cycles -> MCYCLE reads 10; MCYCLEH reads 0.
- Write MHPMEVENT3=2, pulse event_i[1] 5 times -> MHPMCOUNTER3=5, with each increment visible one cycle after its pulse. Write MHPMEVENT3=9 with NUM_EVENTS=8 -> reads back 0.
- Write MCYCLE=FFFF_FFFF with count_en_i high -> next cycle MCYCLE=FFFF_FFFF (write wins); one cycle later MCYCLE=0, MCYCLEH=1.
- Set mcountinhibit bit 2, retire_i high 4 cycles -> MINSTRET unchanged. Clear the bit -> resumes counting. Write mcountinhibit=FFFF_FFFF with NUM_HPM=4 -> reads 0000_007D.
- With CERES_HPM_OVF_IRQ_EN: MHPMCOUNTER4/4H = all-ones, one event -> counter 0, OF=1, ovf_irq_o=1 next cycle. Write MHPMEVENT4 with bit31=0 -> irq drops.
- Write C00 -> csr_hit_o=1, MCYCLE unaffected. Read 0x3FF -> csr_hit_o=0, csr_rdata_o=0.
